// File: rtl/counter_bank_if.sv
// counter_bank_if: register bus between a host (master) and counter_bank (slave).
//   address  : 8-bit register address
//   wrData   : 32-bit write data
//   wrEnable : one-cycle write strobe
//   rdData   : 32-bit registered read data, one cycle after address
interface counter_bank_if;
    logic [7:0]  address;
    logic [31:0] wrData;
    logic        wrEnable;
    logic [31:0] rdData;
    modport master (output address, wrData, wrEnable, input rdData);
    modport slave (input address, wrData, wrEnable, output rdData);
endinterface

// File: rtl/counter_bank.sv
// counter_bank: NUM_CH counter/timer channels on a shared prescaled tick or synchronised event pins.
//   ipClk   : system clock
//   ipReset : asynchronous active-low reset
//   ipEvent : asynchronous per-channel event pins
//   bus     : register bus (address/wrData/wrEnable in, rdData out)
//   opMatch : sticky per-channel compare-match flags (STATUS)
//   opIrq   : any STATUS bit that is enabled in IRQ_EN
module counter_bank #(
    parameter int NUM_CH      = 4,
    parameter int WIDTH       = 32,
    parameter int PRESCALE_W  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              ipClk,
    input  logic              ipReset,
    input  logic [NUM_CH-1:0] ipEvent,
    counter_bank_if.slave     bus,
    output logic [NUM_CH-1:0] opMatch,
    output logic              opIrq
);
    logic [PRESCALE_W-1:0]  prescale, pcnt;
    logic [NUM_CH-1:0]      status, irqEn, sPrev, s, rise, fall;
    logic [NUM_CH-1:0]      ctrlWr, cntWr, cmpWr, stepCond, hold, doStep, setMatch;
    logic [SYNC_STAGES-1:0] syncFf [NUM_CH];
    logic [4:0]             ctrl [NUM_CH];
    logic [WIDTH-1:0]       cnt [NUM_CH];
    logic [WIDTH-1:0]       cmp [NUM_CH];
    logic [WIDTH-1:0]       cap [NUM_CH];
    logic [WIDTH-1:0]       nxt [NUM_CH];
    logic [5:0]             chSel;
    logic                   chHit, preWr, snapWr, statWr, irqWr, tick;
    logic [31:0]            rdNext;

    // Channel registers occupy four consecutive addresses from 0x10.
    assign chSel   = bus.address[7:2] - 6'd4;
    assign chHit   = bus.address >= 8'h10 && int'(chSel) < NUM_CH;
    assign preWr   = bus.wrEnable && bus.address == 8'h00;
    assign snapWr  = bus.wrEnable && bus.address == 8'h01;
    assign statWr  = bus.wrEnable && bus.address == 8'h02;
    assign irqWr   = bus.wrEnable && bus.address == 8'h03;
    // A PRESCALE write restarts the period, so it suppresses the tick of that cycle.
    assign tick    = !preWr && pcnt == prescale;
    assign opMatch = status;
    assign opIrq   = |(status & irqEn);

    always_comb begin
        s        = '0;
        rise     = '0;
        fall     = '0;
        ctrlWr   = '0;
        cntWr    = '0;
        cmpWr    = '0;
        stepCond = '0;
        hold     = '0;
        doStep   = '0;
        setMatch = '0;
        rdNext   = bus.address == 8'h00 ? 32'(prescale) :
                   bus.address == 8'h02 ? 32'(status) :
                   bus.address == 8'h03 ? 32'(irqEn) : '0;
        for (int c = 0; c < NUM_CH; c++) begin
            nxt[c]      = ctrl[c][3] ? cnt[c] - WIDTH'(1) : cnt[c] + WIDTH'(1);
            s[c]        = syncFf[c][SYNC_STAGES-1];
            rise[c]     = s[c] & ~sPrev[c];
            fall[c]     = ~s[c] & sPrev[c];
            ctrlWr[c]   = bus.wrEnable && chHit && chSel == 6'(c) && bus.address[1:0] == 2'd0;
            cntWr[c]    = bus.wrEnable && chHit && chSel == 6'(c) && bus.address[1:0] == 2'd1;
            cmpWr[c]    = bus.wrEnable && chHit && chSel == 6'(c) && bus.address[1:0] == 2'd2;
            stepCond[c] = ctrl[c][0] && (ctrl[c][2:1] == 2'd0 ? tick :
                                         ctrl[c][2:1] == 2'd1 ? rise[c] :
                                         ctrl[c][2:1] == 2'd2 ? fall[c] : tick & s[c]);
            // Saturating channel parked at its end value: no step, so no fresh match either.
            hold[c]     = ctrl[c][4] && (ctrl[c][3] ? cnt[c] == '0 : &cnt[c]);
            // A COUNT write swallows the step and its match.
            doStep[c]   = stepCond[c] && !hold[c] && !cntWr[c];
            setMatch[c] = doStep[c] && nxt[c] == cmp[c];
            if (chHit && chSel == 6'(c))
                rdNext = bus.address[1:0] == 2'd0 ? 32'(ctrl[c]) :
                         bus.address[1:0] == 2'd1 ? 32'(cnt[c]) :
                         bus.address[1:0] == 2'd2 ? 32'(cmp[c]) : 32'(cap[c]);
        end
    end

    always_ff @(posedge ipClk or negedge ipReset) begin
        if (!ipReset) begin
            prescale   <= '0;
            pcnt       <= '0;
            status     <= '0;
            irqEn      <= '0;
            sPrev      <= '0;
            bus.rdData <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                syncFf[c] <= '0;
                ctrl[c]   <= '0;
                cnt[c]    <= '0;
                cmp[c]    <= '0;
                cap[c]    <= '0;
            end
        end else begin
            pcnt       <= preWr || tick ? '0 : pcnt + PRESCALE_W'(1);
            sPrev      <= s;
            bus.rdData <= rdNext;
            // Set wins over a same-cycle write-1-to-clear.
            status     <= (status & ~(statWr ? bus.wrData[NUM_CH-1:0] : '0)) | setMatch;
            if (preWr) prescale <= bus.wrData[PRESCALE_W-1:0];
            if (irqWr) irqEn <= bus.wrData[NUM_CH-1:0];
            for (int c = 0; c < NUM_CH; c++) begin
                syncFf[c] <= {syncFf[c][SYNC_STAGES-2:0], ipEvent[c]};
                if (ctrlWr[c]) ctrl[c] <= bus.wrData[4:0];
                if (cmpWr[c]) cmp[c] <= bus.wrData[WIDTH-1:0];
                if (snapWr) cap[c] <= cnt[c];
                if (cntWr[c]) cnt[c] <= bus.wrData[WIDTH-1:0];
                else if (doStep[c]) cnt[c] <= nxt[c];
            end
        end
    end
endmodule
